// File: rtl/ss_bridge_pkg.sv
// Shared types and defaults for the savestate-to-DDR3 bridge.
package ss_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT
    } state_t;

    localparam logic [28:0] DEFAULT_BASE_ADDR  = 29'h0600_0000;
    localparam int          DEFAULT_SLOT_WORDS = 32768;
    localparam int          OFFSET_W           = $clog2(DEFAULT_SLOT_WORDS);

endpackage

// File: rtl/ss_ddr_bridge.sv
// Turns the savestate toggle handshake into single-beat Avalon-MM accesses
// and generates slot-relative word addresses.
module ss_ddr_bridge
    import ss_bridge_pkg::*;
#(
    parameter logic [28:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          SLOT_WORDS = DEFAULT_SLOT_WORDS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    slot,
    input  logic                          rewind,
    input  logic                          req,
    input  logic                          wren,
    input  logic [63:0]                   req_di,
    output logic [63:0]                   req_do,
    output logic                          ack,
    output logic                          busy,
    output logic [$clog2(SLOT_WORDS)-1:0] word_offset,
    output logic [28:0]                   avm_address,
    output logic                          avm_read,
    output logic                          avm_write,
    output logic [63:0]                   avm_writedata,
    output logic [7:0]                    avm_byteenable,
    output logic [7:0]                    avm_burstcount,
    input  logic                          avm_waitrequest,
    input  logic [63:0]                   avm_readdata,
    input  logic                          avm_readdatavalid
);

    localparam int                OW         = $clog2(SLOT_WORDS);
    localparam logic [OW-1:0]     OFFSET_ONE = 1;

    state_t      state;
    logic [1:0]  slot_r;
    logic [28:0] slot_base;
    logic [28:0] next_addr;

    // SLOT_WORDS is a power of two, so the slot product is a plain shift.
    assign slot_base      = 29'(slot_r) << OW;
    assign next_addr      = BASE_ADDR + slot_base + 29'(word_offset);
    assign avm_byteenable = 8'hFF;
    assign avm_burstcount = 8'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ack           <= 1'b0;
            busy          <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            req_do        <= '0;
            word_offset   <= '0;
            slot_r        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != ack) begin
                        avm_address   <= next_addr;
                        avm_writedata <= req_di;
                        busy          <= 1'b1;
                        if (wren) begin
                            avm_write <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            avm_read  <= 1'b1;
                            state     <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write   <= 1'b0;
                        ack         <= ~ack;
                        word_offset <= word_offset + OFFSET_ONE;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        // Zero-latency slaves may return data in the acceptance cycle.
                        if (avm_readdatavalid) begin
                            req_do      <= avm_readdata;
                            ack         <= ~ack;
                            word_offset <= word_offset + OFFSET_ONE;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (avm_readdatavalid) begin
                        req_do      <= avm_readdata;
                        ack         <= ~ack;
                        word_offset <= word_offset + OFFSET_ONE;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Rewind overrides any offset increment from a completing transfer.
            if (rewind) begin
                slot_r      <= slot;
                word_offset <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ss_ddr_bridge.sv
// Self-checking bench for ss_ddr_bridge: the bench plays the sequencer and a
// word-addressed DDR slave, predicting addresses and data from slot/offset arithmetic.
module tb_ss_ddr_bridge;
    import ss_bridge_pkg::*;

    logic                clk;
    logic                reset_n;
    logic [1:0]          slot;
    logic                rewind;
    logic                req;
    logic                wren;
    logic [63:0]         req_di;
    logic [63:0]         req_do;
    logic                ack;
    logic                busy;
    logic [OFFSET_W-1:0] word_offset;
    logic [28:0]         avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [63:0]         avm_writedata;
    logic [7:0]          avm_byteenable;
    logic [7:0]          avm_burstcount;
    logic                avm_waitrequest;
    logic [63:0]         avm_readdata;
    logic                avm_readdatavalid;

    int                  passed_checks;
    int                  total_checks;
    int                  m_slot;
    int                  m_offset;
    logic                m_ack;
    logic [28:0]         last_addr;
    logic [63:0]         model_mem [int];
    logic [63:0]         slave_mem [int];

    ss_ddr_bridge dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .slot              (slot),
        .rewind            (rewind),
        .req               (req),
        .wren              (wren),
        .req_di            (req_di),
        .req_do            (req_do),
        .ack               (ack),
        .busy              (busy),
        .word_offset       (word_offset),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] expAddr();
        return 29'(longint'(DEFAULT_BASE_ADDR) + longint'(m_slot) * DEFAULT_SLOT_WORDS + m_offset);
    endfunction

    function automatic logic [63:0] slaveRead(input logic [28:0] addr);
        if (slave_mem.exists(int'(addr))) return slave_mem[int'(addr)];
        return 64'h0;
    endfunction

    function automatic logic [63:0] modelRead(input logic [28:0] addr);
        if (model_mem.exists(int'(addr))) return model_mem[int'(addr)];
        return 64'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) begin
            passed_checks++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preloadWord(input logic [28:0] addr, input logic [63:0] data);
        slave_mem[int'(addr)] = data;
        model_mem[int'(addr)] = data;
    endtask

    task automatic applyRewind(input logic [1:0] s);
        rewind = 1'b1;
        slot   = s;
        applyStimulus(1);
        rewind   = 1'b0;
        m_slot   = int'(s);
        m_offset = 0;
        checkOutput("rewind_offset", 64'(word_offset), 64'(0));
    endtask

    task automatic applyWrite(input logic [63:0] data, input int waits, input bit rew, input logic [1:0] rew_slot);
        logic [28:0] addr_exp;
        addr_exp        = expAddr();
        wren            = 1'b1;
        req_di          = data;
        req             = ~m_ack;
        avm_waitrequest = (waits > 0);
        applyStimulus(1);
        last_addr = avm_address;
        checkOutput("wr_addr", 64'(avm_address), 64'(addr_exp));
        checkOutput("wr_data", avm_writedata, data);
        checkOutput("wr_busy", 64'(busy), 64'(1'b1));
        for (int k = 1; k <= waits + 1; k++) begin
            checkOutput("wr_cmd", 64'(avm_write), 64'(1'b1));
            checkOutput("wr_ack_hold", 64'(ack), 64'(m_ack));
            avm_waitrequest = (k <= waits);
            if (k == waits + 1) begin
                rewind = rew;
                slot   = rew_slot;
                slave_mem[int'(avm_address)] = avm_writedata;
            end
            applyStimulus(1);
        end
        rewind          = 1'b0;
        avm_waitrequest = 1'b0;
        model_mem[int'(addr_exp)] = data;
        m_ack    = ~m_ack;
        m_offset = (m_offset + 1) % DEFAULT_SLOT_WORDS;
        if (rew) begin
            m_slot   = int'(rew_slot);
            m_offset = 0;
        end
        checkOutput("wr_ack", 64'(ack), 64'(m_ack));
        checkOutput("wr_cmd_drop", 64'(avm_write), 64'(1'b0));
        checkOutput("wr_idle", 64'(busy), 64'(1'b0));
        checkOutput("wr_offset", 64'(word_offset), 64'(m_offset));
    endtask

    task automatic applyRead(input int waits, input int delay);
        logic [28:0] addr_exp;
        int          held;
        addr_exp          = expAddr();
        held              = 0;
        wren              = 1'b0;
        req               = ~m_ack;
        avm_waitrequest   = (waits > 0);
        avm_readdatavalid = 1'b0;
        applyStimulus(1);
        checkOutput("rd_addr", 64'(avm_address), 64'(addr_exp));
        checkOutput("rd_busy", 64'(busy), 64'(1'b1));
        for (int k = 1; k <= waits + 1; k++) begin
            if (avm_read) held++;
            checkOutput("rd_ack_hold", 64'(ack), 64'(m_ack));
            avm_waitrequest = (k <= waits);
            if (k == waits + 1 && delay == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = slaveRead(avm_address);
            end
            applyStimulus(1);
        end
        avm_waitrequest = 1'b0;
        for (int j = 1; j <= delay; j++) begin
            checkOutput("rd_pending_ack", 64'(ack), 64'(m_ack));
            checkOutput("rd_cmd_drop", 64'(avm_read), 64'(1'b0));
            avm_readdatavalid = (j == delay);
            if (j == delay) avm_readdata = slaveRead(avm_address);
            applyStimulus(1);
        end
        avm_readdatavalid = 1'b0;
        m_ack    = ~m_ack;
        m_offset = (m_offset + 1) % DEFAULT_SLOT_WORDS;
        checkOutput("rd_ack", 64'(ack), 64'(m_ack));
        checkOutput("rd_data", req_do, modelRead(addr_exp));
        checkOutput("rd_cmd_cycles", 64'(held), 64'(waits + 1));
        checkOutput("rd_idle", 64'(busy), 64'(1'b0));
        checkOutput("rd_offset", 64'(word_offset), 64'(m_offset));
    endtask

    initial begin
        clk               = 1'b0;
        reset_n           = 1'b0;
        slot              = 2'd0;
        rewind            = 1'b0;
        req               = 1'b0;
        wren              = 1'b0;
        req_di            = 64'h0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 64'h0;
        avm_readdatavalid = 1'b0;
        passed_checks     = 0;
        total_checks      = 0;
        m_slot            = 0;
        m_offset          = 0;
        m_ack             = 1'b0;
        last_addr         = '0;

        applyStimulus(3);
        reset_n = 1'b1;
        checkOutput("rst_address", 64'(avm_address), 64'(0));
        checkOutput("rst_writedata", avm_writedata, 64'h0);
        checkOutput("rst_req_do", req_do, 64'h0);
        checkOutput("rst_offset", 64'(word_offset), 64'(0));
        checkOutput("byteenable", 64'(avm_byteenable), 64'hFF);
        checkOutput("burstcount", 64'(avm_burstcount), 64'h1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("idle_ack", 64'(ack), 64'(0));
            checkOutput("idle_read", 64'(avm_read), 64'(0));
            checkOutput("idle_write", 64'(avm_write), 64'(0));
            checkOutput("idle_busy", 64'(busy), 64'(0));
        end

        applyRewind(2'd2);
        applyWrite(64'h1111_1111_1111_1111, 0, 1'b0, 2'd0);
        checkOutput("slot2_addr0", 64'(last_addr), 64'(29'h0601_0000));
        applyWrite(64'h2222_2222_2222_2222, 0, 1'b0, 2'd0);
        checkOutput("slot2_addr1", 64'(last_addr), 64'(29'h0601_0001));
        applyWrite(64'h3333_3333_3333_3333, 0, 1'b0, 2'd0);
        checkOutput("slot2_addr2", 64'(last_addr), 64'(29'h0601_0002));
        checkOutput("slot2_offset", 64'(word_offset), 64'(3));

        applyRewind(2'd2);
        preloadWord(29'h0601_0000, 64'hDEADBEEF_CAFEF00D);
        applyRead(4, 3);
        checkOutput("slow_read_data", req_do, 64'hDEADBEEF_CAFEF00D);

        begin
            logic [1:0] rs;
            rs = 2'($urandom_range(0, 3));
            applyRewind(rs);
            for (int i = 0; i < 24; i++)
                applyWrite({$urandom, $urandom}, int'($urandom_range(0, 2)), 1'b0, 2'd0);
            applyRewind(rs);
            for (int i = 0; i < 24; i++)
                applyRead(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        applyWrite(64'hA5A5_5A5A_0F0F_F0F0, 1, 1'b1, 2'd1);
        checkOutput("rewind_on_done", 64'(word_offset), 64'(0));
        applyWrite(64'h0123_4567_89AB_CDEF, 0, 1'b0, 2'd0);
        checkOutput("slot1_addr0", 64'(last_addr), 64'(29'h0600_8000));

        applyRewind(2'd3);
        for (int i = 0; i < DEFAULT_SLOT_WORDS - 1; i++)
            applyWrite(64'(i), 0, 1'b0, 2'd0);
        checkOutput("pre_wrap_offset", 64'(word_offset), 64'(32767));
        applyWrite(64'hFEED_FACE_0000_7FFF, 0, 1'b0, 2'd0);
        checkOutput("wrap_last_addr", 64'(last_addr), 64'(29'h0601_FFFF));
        checkOutput("wrap_offset", 64'(word_offset), 64'(0));
        applyWrite(64'hFEED_FACE_0000_0000, 0, 1'b0, 2'd0);
        checkOutput("wrap_no_cross", 64'(last_addr), 64'(29'h0601_8000));

        wren              = 1'b0;
        req               = ~m_ack;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        applyStimulus(2);
        checkOutput("rw_busy", 64'(busy), 64'(1'b1));
        checkOutput("rw_read_dropped", 64'(avm_read), 64'(1'b0));
        reset_n = 1'b0;
        req     = 1'b0;
        applyStimulus(1);
        reset_n  = 1'b1;
        m_ack    = 1'b0;
        m_slot   = 0;
        m_offset = 0;
        checkOutput("mid_rst_ack", 64'(ack), 64'(0));
        checkOutput("mid_rst_read", 64'(avm_read), 64'(0));
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_offset", 64'(word_offset), 64'(0));
        applyStimulus(1);
        preloadWord(DEFAULT_BASE_ADDR, {$urandom, $urandom});
        applyRead(1, 2);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
